// File: rtl/piano_pkg.sv
// Shared types and sizes for the piano key-to-note selector.
package piano_pkg;

  localparam int unsigned NUM_KEYS = 16;
  localparam int unsigned NOTE_W   = 4;

  typedef logic [NOTE_W-1:0] note_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } sel_state_t;

endpackage

// File: rtl/key_debounce.sv
// One key: two-stage synchroniser plus a tick-driven stability counter.
// The debounced level only flips after STABLE_CNT consecutive ticks that
// see the opposite raw level.
module key_debounce #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick_i,
  input  logic key_i,
  output logic db_o
);

  localparam int unsigned    CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             db_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronise the raw key and debounce it on sample ticks.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      if (tick_i) begin
        if (sync2_q == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          db_q  <= ~db_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/key_note_selector.sv
// Debounces 16 piano keys and reduces them to one active note:
// last-pressed key wins, and on release of the playing note the
// highest still-held key takes over.
module key_note_selector
  import piano_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 50000,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [NOTE_W-1:0]   note_sel,
  output logic                note_on,
  output logic                note_change
);

  localparam int unsigned      DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0]    div_q;
  logic                tick_c;
  logic [NUM_KEYS-1:0] db_c;
  logic [NUM_KEYS-1:0] db_q;
  logic [NUM_KEYS-1:0] rise_c;
  logic [NUM_KEYS-1:0] fall_c;
  note_idx_t           rise_top_c;
  note_idx_t           db_top_c;
  sel_state_t          state_q;
  note_idx_t           sel_q;
  logic                chg_q;

  // Index of the highest set bit; 0 when the vector is empty.
  function automatic note_idx_t highest_idx(input logic [NUM_KEYS-1:0] v);
    note_idx_t idx;
    idx = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (v[i]) idx = note_idx_t'(i);
    end
    return idx;
  endfunction

  // Sample-tick divider: wraps at SAMPLE_DIV-1, tick on the last count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (tick_c) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign tick_c = (div_q == DIV_LAST);

  for (genvar k = 0; k < int'(NUM_KEYS); k++) begin : g_key
    key_debounce #(
      .STABLE_CNT (STABLE_CNT)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .tick_i  (tick_c),
      .key_i   (keys[k]),
      .db_o    (db_c[k])
    );
  end

  // Delayed debounced levels for press/release edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      db_q <= '0;
    end else begin
      db_q <= db_c;
    end
  end

  assign rise_c     = db_c & ~db_q;
  assign fall_c     = ~db_c & db_q;
  assign rise_top_c = highest_idx(rise_c);
  assign db_top_c   = highest_idx(db_c);

  // Note-selection FSM; note_change flags any change of note_sel or note_on.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|rise_c) begin
            state_q <= PLAY;
            sel_q   <= rise_top_c;
            chg_q   <= 1'b1;
          end
        end
        PLAY: begin
          if (|rise_c) begin
            sel_q <= rise_top_c;
            chg_q <= (rise_top_c != sel_q);
          end else if (fall_c[sel_q]) begin
            if (|db_c) begin
              sel_q <= db_top_c;
              chg_q <= (db_top_c != sel_q);
            end else begin
              state_q <= IDLE;
              chg_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign note_sel    = sel_q;
  assign note_on     = (state_q == PLAY);
  assign note_change = chg_q;

endmodule
